pairing_job_scheduler: RTL and testbench
========================================

// Module: pairing_job_scheduler
// PURPOSE
//  Shares one Duursma-Lee pairing core among NREQ requesters. Round-robin arbitration.
//  For each granted job it latches the operands, pulses the core reset and waits for
//  core done. It then returns the F(3^6m) result to the owning requester, with an
//  optional watchdog error. Sits between the protocol/host layer and the pairing core.
// PARAMETERS
//  NREQ      4       number of requesters, 2..8
//  TIMEOUT   20000   watchdog limit in core cycles (RUN state), 1..2^20-1
//  OPW       `WIDTH+1 width of one F(3^m) operand (from inc.v, not overridable)
// PORTS
//  clk        in   1              system clock
//  reset      in   1              synchronous, active-high
//  req_valid  in   NREQ           requester i has a job
//  req_ready  out  NREQ           one-hot 1-cycle pulse: job i accepted
//  req_ops    in   NREQ*4*OPW     per requester {xp,yp,xr,yr}; requester i at [i*4*OPW +: 4*OPW]
//  rsp_valid  out  NREQ           one-hot: result for requester i on rsp_out
//  rsp_ready  in   NREQ           requester i takes the result
//  rsp_out    out  `W6+1          pairing result
//  rsp_err    out  1              result is invalid (watchdog fired)
//  rsp_cycles out  20             core cycles spent on this job
//  core_reset out  1              drives the core's reset
//  core_xp/yp/xr/yr out OPW each  held operands to the core
//  core_done  in   1              core done (level; cleared by core_reset)
//  core_out   in   `W6+1          core result
//  busy       out  1              state != IDLE
// BEHAVIOUR
//  Reset values:
//  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_out=0, rsp_err=0, rsp_cycles=0
//  - core operands=0
//  - core_reset=1: core_reset = reset | (state==LAUNCH), so the core is always reset too.
//  Reset mid-job aborts the job silently; no response is issued.
//  FSM states:
//  - IDLE: if any req_valid, grant g = first set index at/after rr_ptr (cyclic).
//    Pulse req_ready[g] this cycle and latch req_ops slice g into core_*.
//    Latch owner=g, set rr_ptr=(g+1)%NREQ, go to LAUNCH.
//    No req_valid: stay in IDLE.
//  - LAUNCH: 1 cycle with core_reset=1; cnt<=0; go to RUN.
//  - RUN: cnt increments every cycle.
//    - core_done is ignored in the first RUN cycle, since a stale done from the previous job
//      may still be visible.
//    - On core_done: latch rsp_out=core_out, rsp_err=0, rsp_cycles=cnt; go to RESP.
//    - If cnt==TIMEOUT-1 without done: rsp_out=0, rsp_err=1, rsp_cycles=TIMEOUT; go to RESP.
//    - Done and timeout in the same cycle: done wins.
//  - RESP: rsp_valid[owner]=1 and is held stable until rsp_ready[owner]=1.
//    In that cycle go to IDLE; rsp_valid drops next cycle.
//    rsp_ready on other bits is ignored.
//    No new grant in RESP; the earliest next req_ready is in the cycle after leaving RESP.
//  Core operands stay stable from LAUNCH until the next grant.
//  req_valid may drop without being granted; no state is kept for it.
//  req_valid of the owner may stay high in RESP; it is granted again only in its RR turn.
//  Throughput: one job per (3 + core latency + response wait) cycles.
//  cnt saturates at 2^20-1.
// STRUCTURE
//  - inc.v (shared): add `SCH_IDLE=2'd0, `SCH_LAUNCH=2'd1, `SCH_RUN=2'd2, `SCH_RESP=2'd3.
//    Operand/result widths come from the existing `WIDTH/`W6.
//  - Sub-module rr_arbiter (NREQ req, rr_ptr in -> one-hot grant, index out): combinational
//    and reused by future schedulers.
//  - FSM, operand/result registers and watchdog counter live in this module.
//  - The pairing core is instantiated by the parent, not here.
// TESTING (core replaced by a stub: done 50 cycles after reset, out={xp,yp,xr,yr,xp,yp})
//  1 Reset, then req_valid=4'b0001 with ops {1,2,3,4}.
//    -> req_ready[0] pulses 1 cycle, core_reset is high 1 cycle, rsp_valid[0] is asserted.
//    -> rsp_out={1,2,3,4,1,2}, rsp_err=0, rsp_cycles=50.
//  2 req_valid=4'b1111 held, rsp_ready all 1.
//    -> grant order 0,1,2,3,0; each rsp_valid one-hot and matching its owner.
//  3 Owner holds rsp_ready=0 for 30 cycles.
//    -> rsp_valid/rsp_out stay stable; no req_ready during the wait; next grant follows the ack.
//  4 Stub never asserts done, TIMEOUT=100.
//    -> RESP after 100 RUN cycles, rsp_err=1, rsp_out=0, rsp_cycles=100; the next job proceeds.
//  5 Reset asserted in RUN.
//    -> rsp_valid stays 0, core_reset=1, busy=0 next cycle, rr_ptr=0; a fresh job works.
//  6 Stub leaves done high from the previous job.
//    -> the scheduler does not complete in the first RUN cycle; the result is taken only after
//       the new done.

Source files
------------

// File: rtl/pairing_job_scheduler_pkg.sv
// Shared definitions for the pairing job scheduler.
//   - Operand/result widths of the F(3^m) pairing datapath.
//   - Scheduler FSM state encoding.
//   - Packed operand bundle {xp, yp, xr, yr} as presented by each requester.
package pairing_job_scheduler_pkg;

    // F(3^m) element width minus one (two bits per trit, m = 97).
    localparam int WIDTH = 193;
    // F(3^6m) result width minus one.
    localparam int W6    = 6 * (WIDTH + 1) - 1;
    localparam int OPW   = WIDTH + 1;
    localparam int RSPW  = W6 + 1;
    // Width of the per-job core cycle counter.
    localparam int CNTW  = 20;

    typedef enum logic [1:0] {
        SCH_IDLE   = 2'd0,
        SCH_LAUNCH = 2'd1,
        SCH_RUN    = 2'd2,
        SCH_RESP   = 2'd3
    } sch_state_e;

    // xp occupies the most significant OPW bits.
    typedef struct packed {
        logic [OPW-1:0] xp;
        logic [OPW-1:0] yp;
        logic [OPW-1:0] xr;
        logic [OPW-1:0] yr;
    } ops_t;

endpackage

// File: rtl/pairing_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index with the highest priority this cycle
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted request (zero when no request)
//   any   : at least one request is present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        idx = '0;
        // Walk the cyclic order backwards so the last hit is the first
        // request at/after ptr.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
        end
        any   = |req;
        grant = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/pairing_job_scheduler.sv
// Shares one pairing core among NREQ requesters with round-robin arbitration.
// A granted job's operands are latched and held on core_*, the core is reset
// for one LAUNCH cycle, and the result (or a watchdog error) is returned to
// the owning requester with a valid/ready handshake.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester job request / one-cycle accept pulse
//   req_ops               : per-requester {xp,yp,xr,yr}, requester i at [i*4*OPW +: 4*OPW]
//   rsp_valid/rsp_ready   : one-hot response valid / per-requester take
//   rsp_out/err/cycles    : result, watchdog error flag, core cycles spent
//   core_reset, core_xp.. : core control and held operands
//   core_done, core_out   : core completion level and result
//   busy                  : scheduler is not idle
module pairing_job_scheduler
    import pairing_job_scheduler_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*4*OPW-1:0]  req_ops,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [RSPW-1:0]        rsp_out,
    output logic                   rsp_err,
    output logic [CNTW-1:0]        rsp_cycles,
    output logic                   core_reset,
    output logic [OPW-1:0]         core_xp,
    output logic [OPW-1:0]         core_yp,
    output logic [OPW-1:0]         core_xr,
    output logic [OPW-1:0]         core_yr,
    input  logic                   core_done,
    input  logic [RSPW-1:0]        core_out,
    output logic                   busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sch_state_e      state, nstate;
    logic [IW-1:0]   rr_ptr, owner, gidx;
    logic [NREQ-1:0] grant;
    logic            any;
    logic [CNTW-1:0] cnt;
    ops_t            gops, ops_q;
    logic            done_ok, timeout_hit;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    assign gops = req_ops[gidx*4*OPW +: 4*OPW];

    // cnt is 0 only in the first RUN cycle; a done seen there may be left
    // over from the previous job, so it is not trusted.
    assign done_ok     = core_done && (cnt != '0);
    assign timeout_hit = (cnt == CNTW'(TIMEOUT - 1));

    assign core_xp    = ops_q.xp;
    assign core_yp    = ops_q.yp;
    assign core_xr    = ops_q.xr;
    assign core_yr    = ops_q.yr;
    assign core_reset = reset | (state == SCH_LAUNCH);
    assign busy       = (state != SCH_IDLE);

    always_comb begin
        nstate    = state;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state)
            SCH_IDLE: begin
                if (any) nstate = SCH_LAUNCH;
                if (!reset) req_ready = grant;
            end
            SCH_LAUNCH: nstate = SCH_RUN;
            SCH_RUN: begin
                if (done_ok || timeout_hit) nstate = SCH_RESP;
            end
            SCH_RESP: begin
                if (rsp_ready[owner]) nstate = SCH_IDLE;
                if (!reset) rsp_valid = NREQ'(1) << owner;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCH_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            cnt        <= '0;
            ops_q      <= '0;
            rsp_out    <= '0;
            rsp_err    <= 1'b0;
            rsp_cycles <= '0;
        end else begin
            state <= nstate;
            unique case (state)
                SCH_IDLE: begin
                    if (any) begin
                        ops_q  <= gops;
                        owner  <= gidx;
                        rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    end
                end
                SCH_LAUNCH: cnt <= '0;
                SCH_RUN: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    // Done takes priority over a coincident watchdog expiry.
                    if (done_ok) begin
                        rsp_out    <= core_out;
                        rsp_err    <= 1'b0;
                        rsp_cycles <= cnt;
                    end else if (timeout_hit) begin
                        rsp_out    <= '0;
                        rsp_err    <= 1'b1;
                        rsp_cycles <= CNTW'(TIMEOUT);
                    end
                end
                SCH_RESP: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pairing_job_scheduler.sv
// Scoreboard bench for pairing_job_scheduler with a stub pairing core.
// The stub raises done LAT cycles after its reset and leaves a stale done
// visible for one cycle after each reset; result = {xp,yp,xr,yr,xp,yp}.
module tb_pairing_job_scheduler;
    import pairing_job_scheduler_pkg::*;

    localparam int NREQ     = 4;
    localparam int TIMEOUT  = 100;
    localparam int LAT_HANG = 1 << 30;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*4*OPW-1:0]  req_ops;
    logic [RSPW-1:0]        rsp_out, core_out;
    logic                   rsp_err, core_reset, core_done, busy;
    logic [CNTW-1:0]        rsp_cycles;
    logic [OPW-1:0]         core_xp, core_yp, core_xr, core_yr;

    always #5 clk = ~clk;

    pairing_job_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_ops(req_ops),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_err(rsp_err), .rsp_cycles(rsp_cycles),
        .core_reset(core_reset),
        .core_xp(core_xp), .core_yp(core_yp), .core_xr(core_xr), .core_yr(core_yr),
        .core_done(core_done), .core_out(core_out), .busy(busy)
    );

    // ---------------- stub core ----------------
    int   sc = 0, lat_cur = 50, next_lat = 50;
    logic stale_q = 1'b0;
    assign core_done = (sc >= lat_cur) || stale_q;
    assign core_out  = {core_xp, core_yp, core_xr, core_yr, core_xp, core_yp};
    always @(posedge clk) begin
        if (core_reset) begin
            sc      <= 0;
            lat_cur <= next_lat;
            stale_q <= core_done;
        end else begin
            stale_q <= 1'b0;
            if (sc < lat_cur) sc <= sc + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [NREQ-1:0] own;
        logic [RSPW-1:0] out;
        logic            err;
        logic [CNTW-1:0] cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   ptr_m = 0, wait_cnt = 0, jobs_done = 0;
    bit   free_m = 1'b1, launch_m = 1'b0, rand_lat = 1'b0;

    task automatic chk(input string nm, input logic [RSPW-1:0] act, input logic [RSPW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h wanted %h (low 128 bits)", nm, act[127:0], exp[127:0]);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic int pick_lat();
        int r = int'($urandom_range(0, 9));
        case (r)
            0:       return int'($urandom_range(0, 5));
            5:       return 98;
            6:       return 99;
            7:       return 100;
            8:       return 101;
            9:       return LAT_HANG;
            default: return int'($urandom_range(45, 55));
        endcase
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0]  exp_rdy;
        logic [4*OPW-1:0] o;
        int               g, eff;
        exp_t             e;
        if (reset) begin
            chk("reset_req_ready", req_ready, '0);
            chk("reset_rsp_valid", rsp_valid, '0);
            chk("reset_core_reset", core_reset, 1'b1);
            q.delete();
            free_m = 1'b1; launch_m = 1'b0; ptr_m = 0; wait_cnt = 0;
        end else begin
            chk("busy", busy, !free_m);
            chk("core_reset", core_reset, launch_m);
            launch_m = 1'b0;
            // Expected grant: first requester at/after the model's pointer.
            exp_rdy = '0;
            g = -1;
            if (free_m) begin
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                o     = req_ops[g*4*OPW +: 4*OPW];
                e.own = exp_rdy;
                eff   = (next_lat == 0) ? 1 : next_lat;
                if (eff < TIMEOUT) begin
                    e.out = {o[4*OPW-1 -: OPW], o[3*OPW-1 -: OPW], o[2*OPW-1 -: OPW],
                             o[OPW-1 -: OPW], o[4*OPW-1 -: OPW], o[3*OPW-1 -: OPW]};
                    e.err = 1'b0;
                    e.cyc = CNTW'(eff);
                end else begin
                    e.out = '0;
                    e.err = 1'b1;
                    e.cyc = CNTW'(TIMEOUT);
                end
                q.push_back(e);
                ptr_m = (g + 1) % NREQ;
                free_m = 1'b0; launch_m = 1'b1; wait_cnt = 0;
            end
            if (rsp_valid != '0) begin
                if (q.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    e = q[0];
                    chk("rsp_valid", rsp_valid, e.own);
                    chk("rsp_out", rsp_out, e.out);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_cycles", rsp_cycles, e.cyc);
                    if ((e.own & rsp_ready) != '0) begin
                        void'(q.pop_front());
                        free_m = 1'b1;
                        jobs_done++;
                        if (rand_lat) next_lat = pick_lat();
                    end
                end
            end else if (!free_m) begin
                wait_cnt++;
                if (wait_cnt > 400) begin
                    fail("rsp_wait");
                    free_m = 1'b1;
                    q.delete();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_jobs(input int n, input int budget);
        int target = jobs_done + n;
        int c = 0;
        while (jobs_done < target && c < budget) begin
            step(1);
            c++;
        end
        if (jobs_done < target) fail("job_budget");
    endtask

    function automatic logic [NREQ*4*OPW-1:0] rand_ops();
        logic [NREQ*4*OPW-1:0] v = '0;
        for (int i = 0; i <= NREQ*4*OPW/32; i++) v = {v[NREQ*4*OPW-33:0], $urandom()};
        return v;
    endfunction

    initial begin
        int c;
        reset = 1'b1; req_valid = '0; rsp_ready = '0; req_ops = '0;
        step(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_out", rsp_out, '0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_cycles", rsp_cycles, '0);
        chk("rst_core_ops", {core_xp, core_yp, core_xr, core_yr}, '0);
        step(1);

        // Single job from requester 0 with ops {1,2,3,4}.
        req_ops[4*OPW-1:0] = {OPW'(1), OPW'(2), OPW'(3), OPW'(4)};
        req_valid = 4'b0001; rsp_ready = '1;
        wait_jobs(1, 300);
        req_valid = '0;

        // All requesters held: grant order from a fresh pointer.
        reset = 1'b1; step(1); reset = 1'b0;
        req_ops = rand_ops(); req_valid = '1; rsp_ready = '1;
        wait_jobs(5, 1500);
        req_valid = '0;

        // Owner stalls the response for 30 cycles.
        req_valid = '1; rsp_ready = '0;
        c = 0;
        while (rsp_valid == '0 && c < 300) begin step(1); c++; end
        if (rsp_valid == '0) fail("stall_rsp");
        step(30);
        rsp_ready = '1;
        wait_jobs(2, 600);
        req_valid = '0;

        // Core hangs: watchdog, then a normal job.
        next_lat = LAT_HANG; req_valid = 4'b0010;
        wait_jobs(1, 400);
        next_lat = 50;
        wait_jobs(1, 400);
        req_valid = '0;

        // Reset while the core is running, then a fresh job.
        next_lat = 50; req_valid = 4'b1000;
        c = 0;
        while (!busy && c < 20) begin step(1); c++; end
        step(10);
        reset = 1'b1; step(1); reset = 1'b0;
        req_valid = '1;
        wait_jobs(1, 400);
        req_valid = '0;

        // Randomised traffic.
        rand_lat = 1'b1; next_lat = pick_lat();
        step(2);
        for (int i = 0; i < 20000 && jobs_done < 130; i++) begin
            req_valid = NREQ'($urandom());
            rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                         ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            if ($urandom_range(0, 7) == 0) req_ops = rand_ops();
            step(1);
        end
        if (jobs_done < 130) fail("random_jobs");
        req_valid = '0; rsp_ready = '1;
        step(300);
        chk("idle_at_end", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
